// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready on both
// sides and saturating counters of corrected / uncorrectable results.
// Codeword bit 0 is overall even parity; positions 1..N-1 are standard Hamming with
// parity at powers of two and data packed into the remaining positions, LSB first.
// The P derivation below covers DATA_W up to 1013.
module hamming_secded_decoder #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned P     = (DATA_W <= 1)   ? 2 :
                                    (DATA_W <= 4)   ? 3 :
                                    (DATA_W <= 11)  ? 4 :
                                    (DATA_W <= 26)  ? 5 :
                                    (DATA_W <= 57)  ? 6 :
                                    (DATA_W <= 120) ? 7 :
                                    (DATA_W <= 247) ? 8 :
                                    (DATA_W <= 502) ? 9 : 10,
    localparam int unsigned N     = DATA_W + P + 1,
    localparam int unsigned POS_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic [POS_W-1:0]  out_err_pos,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    // Codeword position holding data bit k (k-th non-power-of-two index in 1..N-1).
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned cnt = 0;
        int unsigned pos = 0;
        for (int unsigned i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              r_v1;
    logic [N-1:0]      r_code1;
    logic [P-1:0]      r_syn1;
    logic              r_pa1;
    logic              r_v2;
    logic [DATA_W-1:0] r_data2;
    logic              r_corr2;
    logic              r_unc2;
    logic [POS_W-1:0]  r_pos2;
    logic [CNT_W-1:0]  r_cnt_corr;
    logic [CNT_W-1:0]  r_cnt_unc;

    logic              w_adv;
    logic              w_acc;
    logic              w_out_hs;
    logic [P-1:0]      w_syn;
    logic              w_pa;
    logic [N-1:0]      w_fix;
    logic              w_hit;
    logic              w_corr;
    logic              w_unc;
    logic [POS_W-1:0]  w_pos;
    logic [DATA_W-1:0] w_data;

    // Stage 2 can take a new entry when empty or when its result leaves this cycle.
    assign w_adv    = !r_v2 || out_ready;
    assign in_ready = !r_v1 || w_adv;
    assign w_acc    = in_valid && in_ready;
    assign w_out_hs = r_v2 && out_ready;

    // Syndrome is the XOR of the indices of all set bits; pa is overall parity.
    always_comb begin
        w_syn = '0;
        w_pa  = ^in_code;
        for (int unsigned i = 1; i < N; i++) begin
            if (in_code[i]) begin
                w_syn = w_syn ^ P'(i);
            end
        end
    end

    // Classify the stage-1 word, flip the located bit and extract message bits.
    always_comb begin
        w_fix  = r_code1;
        w_hit  = 1'b0;
        w_corr = 1'b0;
        w_unc  = 1'b0;
        w_pos  = '0;
        w_data = '0;
        // A syndrome pointing past the codeword can never come from a single flip.
        for (int unsigned i = 1; i < N; i++) begin
            if (r_syn1 == P'(i)) begin
                w_hit = 1'b1;
            end
        end
        if (r_pa1) begin
            if (r_syn1 == '0) begin
                w_corr = 1'b1;
            end else if (w_hit) begin
                w_corr = 1'b1;
                w_pos  = POS_W'(r_syn1);
                for (int unsigned i = 1; i < N; i++) begin
                    if (r_syn1 == P'(i)) begin
                        w_fix[i] = ~r_code1[i];
                    end
                end
            end else begin
                w_unc = 1'b1;
            end
        end else if (r_syn1 != '0) begin
            w_unc = 1'b1;
        end
        for (int unsigned k = 0; k < DATA_W; k++) begin
            w_data[k] = w_fix[POS_W'(data_pos(k))];
        end
    end

    // Stage 1: capture the accepted codeword with its syndrome and parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_code1 <= '0;
            r_syn1  <= '0;
            r_pa1   <= 1'b0;
        end else if (w_acc) begin
            r_v1    <= 1'b1;
            r_code1 <= in_code;
            r_syn1  <= w_syn;
            r_pa1   <= w_pa;
        end else if (w_adv) begin
            r_v1 <= 1'b0;
        end
    end

    // Stage 2: register the decoded result; holds while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_data2 <= '0;
            r_corr2 <= 1'b0;
            r_unc2  <= 1'b0;
            r_pos2  <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_data2 <= w_data;
            r_corr2 <= w_corr;
            r_unc2  <= w_unc;
            r_pos2  <= w_pos;
        end
    end

    // Saturating statistics counters; clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (clr_cnt) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (w_out_hs) begin
            if (r_corr2 && (r_cnt_corr != '1)) begin
                r_cnt_corr <= r_cnt_corr + 1'b1;
            end
            if (r_unc2 && (r_cnt_unc != '1)) begin
                r_cnt_unc <= r_cnt_unc + 1'b1;
            end
        end
    end

    assign out_valid         = r_v2;
    assign out_data          = r_data2;
    assign out_corrected     = r_corr2;
    assign out_uncorrectable = r_unc2;
    assign out_err_pos       = r_pos2;
    assign cnt_corr          = r_cnt_corr;
    assign cnt_uncorr        = r_cnt_unc;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=4, CNT_W=2): directed
// vectors, backpressure, counter saturation/clear, reset, and a randomized stream
// scored against a textbook encoder plus known injected errors.
module tb_hamming_secded_decoder;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned NW = 8;
    localparam int unsigned PW = 3;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          corr;
        logic          unc;
        logic [PW-1:0] pos;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_code;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_corrected;
    logic          out_uncorrectable;
    logic [PW-1:0] out_err_pos;
    logic          clr_cnt;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_uncorr;

    int n_pass  = 0;
    int n_total = 0;

    hamming_secded_decoder #(
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_code          (in_code),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_corrected    (out_corrected),
        .out_uncorrectable(out_uncorrectable),
        .out_err_pos      (out_err_pos),
        .clr_cnt          (clr_cnt),
        .cnt_corr         (cnt_corr),
        .cnt_uncorr       (cnt_uncorr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit is_pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Textbook encoder: place data, then each parity bit covers indices with its bit set.
    function automatic logic [NW-1:0] encode(input logic [DW-1:0] d);
        logic [NW-1:0] c = '0;
        int k = 0;
        for (int i = 1; i < NW; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int j = 0; j < PW; j++) begin
            logic par = 1'b0;
            for (int i = 1; i < NW; i++) begin
                if (((i >> j) & 1) == 1 && !is_pow2(i)) par ^= c[i];
            end
            c[1 << j] = par;
        end
        c[0] = ^c[NW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [NW-1:0] c);
        logic [DW-1:0] d = '0;
        int k = 0;
        for (int i = 1; i < NW; i++) begin
            if (!is_pow2(i)) begin
                d[k] = c[i];
                k++;
            end
        end
        return d;
    endfunction

    // Send one word with the sink always ready and check the result two cycles later.
    task automatic send(input string tag, input logic [NW-1:0] code, input logic [DW-1:0] ed,
                        input logic ec, input logic eu, input logic [PW-1:0] ep);
        @(negedge clk);
        in_valid = 1'b1; in_code = code; out_ready = 1'b1;
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, ".early_valid"}, 32'(out_valid), 0);
        @(negedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 1);
        chk({tag, ".data"}, 32'(out_data), 32'(ed));
        chk({tag, ".corr"}, 32'(out_corrected), 32'(ec));
        chk({tag, ".unc"}, 32'(out_uncorrectable), 32'(eu));
        chk({tag, ".pos"}, 32'(out_err_pos), 32'(ep));
        @(negedge clk);
        #1 chk({tag, ".valid_drop"}, 32'(out_valid), 0);
    endtask

    exp_t          q[$];
    exp_t          e;
    exp_t          bp_exp[3];
    exp_t          saved;
    exp_t          cur_exp;
    logic [NW-1:0] cur_code;
    logic [DW-1:0] d;
    logic          pend;
    logic          stalled;
    logic [CW-1:0] m_c;
    logic [CW-1:0] m_u;
    int            got;
    int            nerr;
    int            p1;
    int            p2;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.cnt_corr", 32'(cnt_corr), 0);
        chk("rst.cnt_uncorr", 32'(cnt_uncorr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send("clean", 8'hAA, 4'hB, 1'b0, 1'b0, 3'd0);
        chk("clean.cnt_corr", 32'(cnt_corr), 0);
        chk("clean.cnt_uncorr", 32'(cnt_uncorr), 0);
        send("bit6", 8'hEA, 4'hB, 1'b1, 1'b0, 3'd6);
        chk("bit6.cnt_corr", 32'(cnt_corr), 1);
        send("bit0", 8'hAB, 4'hB, 1'b1, 1'b0, 3'd0);
        chk("bit0.cnt_corr", 32'(cnt_corr), 2);
        send("bit1", 8'hA8, 4'hB, 1'b1, 1'b0, 3'd1);
        chk("bit1.cnt_corr", 32'(cnt_corr), 3);
        send("double", 8'hE8, 4'hF, 1'b0, 1'b1, 3'd0);
        chk("double.cnt_uncorr", 32'(cnt_uncorr), 1);
        chk("double.cnt_corr", 32'(cnt_corr), 3);

        // Clear, then saturate with five corrected words.
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        #1;
        chk("clr.cnt_corr", 32'(cnt_corr), 0);
        chk("clr.cnt_uncorr", 32'(cnt_uncorr), 0);
        for (int i = 0; i < 5; i++) begin
            send("sat", 8'hEA, 4'hB, 1'b1, 1'b0, 3'd6);
            chk("sat.cnt_corr", 32'(cnt_corr), (i + 1 > 3) ? 3 : i + 1);
        end

        // Clear in the same cycle as a corrected handshake.
        @(negedge clk); in_valid = 1'b1; in_code = 8'hEA; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); clr_cnt = 1'b1;
        #1;
        chk("clrhs.out_valid", 32'(out_valid), 1);
        chk("clrhs.cnt_before", 32'(cnt_corr), 3);
        @(negedge clk); clr_cnt = 1'b0;
        #1 chk("clrhs.cnt_after", 32'(cnt_corr), 0);

        // Backpressure: three words offered with the sink stalled for four cycles.
        bp_exp[0] = '{data: 4'hB, corr: 1'b0, unc: 1'b0, pos: 3'd0};
        bp_exp[1] = '{data: 4'hB, corr: 1'b1, unc: 1'b0, pos: 3'd6};
        bp_exp[2] = '{data: 4'hF, corr: 1'b0, unc: 1'b1, pos: 3'd0};
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_code = 8'hAA;
        #1 chk("bp.rdy0", 32'(in_ready), 1);
        @(negedge clk); in_code = 8'hEA;
        #1 chk("bp.rdy1", 32'(in_ready), 1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); in_code = 8'hE8;
            #1;
            chk("bp.rdy_full", 32'(in_ready), 0);
            chk("bp.hold_valid", 32'(out_valid), 1);
            chk("bp.hold_out", 32'({out_data, out_corrected, out_uncorrectable, out_err_pos}),
                32'(bp_exp[0]));
        end
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) out_ready = 1'b1;
            else in_valid = 1'b0;
            #1;
            if (c == 0) chk("bp.rdy_release", 32'(in_ready), 1);
            if (out_valid) begin
                if (got < 3) begin
                    chk("bp.order", 32'({out_data, out_corrected, out_uncorrectable, out_err_pos}),
                        32'(bp_exp[got]));
                end else begin
                    chk("bp.extra_output", 32'(out_valid), 0);
                end
                got++;
            end
        end
        chk("bp.count", 32'(got), 3);
        chk("bp.cnt_corr", 32'(cnt_corr), 1);
        chk("bp.cnt_uncorr", 32'(cnt_uncorr), 1);

        // Randomized stream against the scoreboard.
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        m_c = '0; m_u = '0; pend = 1'b0; stalled = 1'b0; saved = '0;
        cur_code = '0; cur_exp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!pend && $urandom_range(0, 3) != 0) begin
                d    = DW'($urandom);
                nerr = $urandom_range(0, 2);
                p1   = $urandom_range(0, NW - 1);
                p2   = (p1 + $urandom_range(1, NW - 1)) % NW;
                cur_code = encode(d);
                cur_exp  = '{data: d, corr: 1'b0, unc: 1'b0, pos: '0};
                if (nerr >= 1) begin
                    cur_code[p1] = ~cur_code[p1];
                    cur_exp.corr = 1'b1;
                    cur_exp.pos  = PW'(p1);
                end
                if (nerr == 2) begin
                    cur_code[p2] = ~cur_code[p2];
                    cur_exp = '{data: extract(cur_code), corr: 1'b0, unc: 1'b1, pos: '0};
                end
                pend = 1'b1;
            end
            in_valid  = pend;
            in_code   = cur_code;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            #1;
            chk("rnd.cnt_corr", 32'(cnt_corr), 32'(m_c));
            chk("rnd.cnt_uncorr", 32'(cnt_uncorr), 32'(m_u));
            chk("rnd.in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            if (stalled) begin
                chk("rnd.stall_valid", 32'(out_valid), 1);
                chk("rnd.stall_hold",
                    32'({out_data, out_corrected, out_uncorrectable, out_err_pos}), 32'(saved));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd.spurious", 32'(out_valid), 0);
                end else begin
                    e = q[0];
                    chk("rnd.result",
                        32'({out_data, out_corrected, out_uncorrectable, out_err_pos}), 32'(e));
                    chk("rnd.exclusive", 32'(out_corrected && out_uncorrectable), 0);
                end
            end
            e = '0;
            if (out_valid && out_ready && q.size() > 0) e = q.pop_front();
            if (clr_cnt) begin
                m_c = '0;
                m_u = '0;
            end else begin
                if (e.corr && m_c != CMAX) m_c = m_c + 1'b1;
                if (e.unc && m_u != CMAX) m_u = m_u + 1'b1;
            end
            stalled = out_valid && !out_ready;
            saved   = '{data: out_data, corr: out_corrected, unc: out_uncorrectable,
                        pos: out_err_pos};
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                pend = 1'b0;
            end
        end

        // Reset mid-stream with a stalled, occupied pipeline.
        @(negedge clk); clr_cnt = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_code = 8'hEA;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mrst.pre_valid", 32'(out_valid), 1);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 0);
        chk("mrst.in_ready", 32'(in_ready), 1);
        chk("mrst.flags", 32'({out_data, out_corrected, out_uncorrectable, out_err_pos}), 0);
        chk("mrst.cnt_corr", 32'(cnt_corr), 0);
        chk("mrst.cnt_uncorr", 32'(cnt_uncorr), 0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("mrst.no_stale", 32'(out_valid), 0);
            chk("mrst.in_ready_after", 32'(in_ready), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Parametrised, pipelined extended-Hamming (SECDED) decoder.
- Takes a codeword with an overall-parity bit and DATA_W message bits. Corrects any single-bit error, detects double-bit errors, and returns the message bits.
- Sits between the fault-injection/channel path and the switch/LED message sink.
- Uses a valid/ready stream on both sides and keeps saturating error-statistics counters.

Parameters:
- DATA_W, 4, message bits per codeword (≥1).
- CNT_W, 16, width of each statistics counter.
- Derived, not overridable: P = smallest integer with 2^P ≥ DATA_W+P+1. N = DATA_W+P+1 (codeword width). POS_W = max(1, clog2(N)). For DATA_W=4 these are P=3, N=8, POS_W=3.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder accepts codeword this cycle.
- in_code  in  N  codeword, bit 0 = overall parity.
- out_valid  out  1  decoded result present.
- out_ready  in  1  sink accepts result.
- out_data  out  DATA_W  corrected message.
- out_corrected  out  1  single error found and fixed.
- out_uncorrectable  out  1  double or invalid error; out_data not trustworthy.
- out_err_pos  out  POS_W  corrected bit index (0 when none or uncorrectable).
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_corr  out  CNT_W  accepted results with out_corrected=1.
- cnt_uncorr  out  CNT_W  accepted results with out_uncorrectable=1.

Behaviour:
- Codeword layout:
  - Positions 1..N-1 form standard Hamming. Parity sits at power-of-two positions; data occupies the remaining positions in ascending order, data[0] at the lowest.
  - Bit 0 makes the XOR of all N bits equal 0 (even parity).
  - DATA_W=4 mapping: data[3:0] = {code[7], code[6], code[5], code[3]}.
- Stage 1, on acceptance (in_valid && in_ready), registers:
  - in_code;
  - syndrome s = XOR of indices i in 1..N-1 where code[i]=1 (P bits);
  - pa = XOR of all N bits.
- Stage 2 classifies and corrects:
  - s=0, pa=0: clean; flags 0; err_pos 0.
  - pa=1, s=0: bit 0 in error; corrected=1; err_pos=0; data unchanged.
  - pa=1, 1≤s≤N-1: flip bit s; corrected=1; err_pos=s.
  - pa=1, s≥N: uncorrectable=1.
  - pa=0, s≠0: double error; uncorrectable=1; out_data = raw extracted data bits.
  - out_corrected and out_uncorrectable are never both 1.
- Pipeline and handshake:
  - Two register stages, each with a valid bit. Latency is 2 cycles from acceptance to out_valid with out_ready held high; throughput is 1 per cycle.
  - Stage 2 loads when !v2 || out_ready. Stage 1 advances into stage 2 under the same condition.
  - in_ready = !v1 || !v2 || out_ready (purely combinational; no dependence on in_valid).
  - While out_valid=1 && out_ready=0, all out_* hold stable. No codeword is dropped or duplicated.
- Counters:
  - Increment on output handshake (out_valid && out_ready) per flag.
  - Saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt forces 0 next cycle and wins over a simultaneous increment.
- Reset, including mid-stream: both valid bits, out_valid, out_data, flags, out_err_pos and both counters go to 0 immediately. Any in-flight codewords are discarded. in_ready reads 1 during and after reset.

Test Plan:
- Clean: in_code=8'hAA (data 4'hB), out_ready=1 → out_valid 2 cycles later, out_data=4'hB, flags 0, err_pos=0, counters 0.
- Single data-bit error: in_code=8'hEA (bit 6 flipped) → out_data=4'hB, out_corrected=1, out_err_pos=6, cnt_corr=1.
- Parity-bit errors:
  - in_code=8'hAB (bit 0 flipped) → out_data=4'hB, corrected=1, err_pos=0.
  - in_code=8'hA8 (bit 1 flipped) → out_data=4'hB, corrected=1, err_pos=1.
- Double error: in_code=8'hE8 (bits 6,1 flipped; s=7, pa=0) → out_uncorrectable=1, out_corrected=0, err_pos=0, cnt_uncorr=1.
- Backpressure: stream 8'hAA, 8'hEA, 8'hE8 back-to-back with out_ready=0 for 4 cycles:
  - in_ready falls after 2 codewords accepted;
  - outputs hold stable while stalled;
  - on release all 3 results emerge in order with no loss.
- Saturation, clear and reset: CNT_W=2, send 5 corrected words → cnt_corr=3. Pulse clr_cnt in the same cycle as a corrected handshake → 0. Assert rst mid-stream → out_valid=0 at once, and no stale output appears after rst falls.
